hazard_scoreboard: RTL and testbench

Parametrised pipeline hazard unit for the 5-stage core that adds a register scoreboard for a long-latency multiply/divide unit, alongside the classic load-use stall and M/W forwarding. It sits in the controlpath. It takes register addresses and control bits from D, E, M and W plus the mul/div unit's handshake, and drives stall, flush and forward-select signals to the datapath. It also keeps free-running stall/flush performance counters.

---
 rtl/hazard_scoreboard.sv | 139 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core: load-use stall, M/W/md forwarding and
// a pending-write scoreboard for the long-latency mul/div unit.
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_use_rs1,
    input  logic              d_use_rs2,
    input  logic              d_reg_write,
    input  logic              d_is_md,
    input  logic [REG_AW-1:0] e_rs1,
    input  logic [REG_AW-1:0] e_rs2,
    input  logic [REG_AW-1:0] e_rd,
    input  logic              e_reg_write,
    input  logic [1:0]        e_result_src,
    input  logic              e_pc_src,
    input  logic [REG_AW-1:0] m_rd,
    input  logic [REG_AW-1:0] w_rd,
    input  logic              m_reg_write,
    input  logic              w_reg_write,
    input  logic              md_busy,
    input  logic              md_done,
    input  logic [REG_AW-1:0] md_rd,
    output logic              f_stall,
    output logic              d_stall,
    output logic              d_flush,
    output logic              e_flush,
    output logic [1:0]        e_forward_a,
    output logic [1:0]        e_forward_b,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    localparam int NREGS = 2**REG_AW;

    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    logic md_in_e;
    logic d_reads_e;
    logic load_use;
    logic sb_raw;
    logic md_raw;
    logic waw;
    logic structural;
    logic stall;

    // Register 0 never has a pending write, whatever the array holds.
    function automatic logic sb_pending(input logic [NREGS-1:0] v,
                                        input logic [REG_AW-1:0] r);
        return (r != '0) && v[r];
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0) begin
            if (m_reg_write && m_rd == rs)
                sel = 2'b10;
            else if (md_done && md_rd == rs)
                sel = 2'b11;
            else if (w_reg_write && w_rd == rs)
                sel = 2'b01;
        end
        return sel;
    endfunction

    assign md_in_e = (e_result_src == 2'b11) && e_reg_write && (e_rd != '0);

    assign d_reads_e = (d_use_rs1 && d_rs1 == e_rd)
                    || (d_use_rs2 && d_rs2 == e_rd);

    assign load_use = (e_result_src == 2'b01) && (e_rd != '0) && d_reads_e;

    assign sb_raw = (d_use_rs1 && sb_pending(sb, d_rs1))
                 || (d_use_rs2 && sb_pending(sb, d_rs2));

    assign md_raw = md_in_e && d_reads_e;

    assign waw = d_reg_write && (d_rd != '0)
              && (sb_pending(sb, d_rd) || (md_in_e && e_rd == d_rd));

    assign structural = d_is_md && (md_busy || e_result_src == 2'b11);

    assign stall = load_use | sb_raw | md_raw | waw | structural;

    always_comb begin
        f_stall     = 1'b0;
        d_stall     = 1'b0;
        d_flush     = 1'b0;
        e_flush     = 1'b0;
        e_forward_a = 2'b00;
        e_forward_b = 2'b00;
        if (!rst) begin
            // A redirect flushes D, so holding F/D would be pointless.
            f_stall     = stall & ~e_pc_src;
            d_stall     = stall & ~e_pc_src;
            d_flush     = e_pc_src;
            e_flush     = stall | e_pc_src;
            e_forward_a = fwd_sel(e_rs1);
            e_forward_b = fwd_sel(e_rs2);
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (md_in_e)
            set_mask[e_rd] = 1'b1;
        if (md_done && md_rd != '0)
            clr_mask[md_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb           <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            sb <= (sb & ~clr_mask) | set_mask;
            if (f_stall)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (e_pc_src)
                flush_events <= flush_events + CNT_W'(1);
        end
    end

    // A mul/div result cannot complete in the cycle right after its op left E.
    a_md_early : assert property (@(posedge clk) disable iff (rst)
        md_in_e |=> !md_done)
        else $error("md_done arrived one cycle after the md op was in E");

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard; a driver queues expected
// outputs and a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    logic              clk;
    logic              rst;
    logic [REG_AW-1:0] d_rs1, d_rs2, d_rd;
    logic              d_use_rs1, d_use_rs2, d_reg_write, d_is_md;
    logic [REG_AW-1:0] e_rs1, e_rs2, e_rd;
    logic              e_reg_write;
    logic [1:0]        e_result_src;
    logic              e_pc_src;
    logic [REG_AW-1:0] m_rd, w_rd;
    logic              m_reg_write, w_reg_write;
    logic              md_busy, md_done;
    logic [REG_AW-1:0] md_rd;
    logic              f_stall, d_stall, d_flush, e_flush;
    logic [1:0]        e_forward_a, e_forward_b;
    logic [CNT_W-1:0]  stall_cycles, flush_events;

    typedef struct {
        string       name;
        logic        fs;
        logic        df;
        logic        ef;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] sc;
        logic [31:0] fe;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_sc = 0;
    int   exp_fe = 0;
    bit   drive_done = 0;

    hazard_scoreboard #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .d_reg_write(d_reg_write), .d_is_md(d_is_md),
        .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
        .e_reg_write(e_reg_write), .e_result_src(e_result_src),
        .e_pc_src(e_pc_src),
        .m_rd(m_rd), .w_rd(w_rd),
        .m_reg_write(m_reg_write), .w_reg_write(w_reg_write),
        .md_busy(md_busy), .md_done(md_done), .md_rd(md_rd),
        .f_stall(f_stall), .d_stall(d_stall),
        .d_flush(d_flush), .e_flush(e_flush),
        .e_forward_a(e_forward_a), .e_forward_b(e_forward_b),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rst = 0;
        d_rs1 = 0; d_rs2 = 0; d_rd = 0;
        d_use_rs1 = 0; d_use_rs2 = 0; d_reg_write = 0; d_is_md = 0;
        e_rs1 = 0; e_rs2 = 0; e_rd = 0;
        e_reg_write = 0; e_result_src = 2'b00; e_pc_src = 0;
        m_rd = 0; w_rd = 0; m_reg_write = 0; w_reg_write = 0;
        md_busy = 0; md_done = 0; md_rd = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Queue the expectation for the vector currently driven, then advance
    // the counter model by what this cycle contributes at the next edge.
    task automatic expect_vec(input string name, input logic fs,
                              input logic df, input logic ef,
                              input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.name = name; e.fs = fs; e.df = df; e.ef = ef;
        e.fa = fa; e.fb = fb;
        e.sc = exp_sc; e.fe = exp_fe;
        exp_q.push_back(e);
        if (rst) begin
            exp_sc = 0;
            exp_fe = 0;
        end else begin
            exp_sc += int'(fs);
            exp_fe += int'(df);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (f_stall !== e.fs || d_stall !== e.fs || d_flush !== e.df
                || e_flush !== e.ef || e_forward_a !== e.fa
                || e_forward_b !== e.fb || stall_cycles !== e.sc
                || flush_events !== e.fe) begin
                errors++;
                $display("FAIL %s: got fs=%b ds=%b df=%b ef=%b fa=%b fb=%b sc=%0d fe=%0d want fs=%b ds=%b df=%b ef=%b fa=%b fb=%b sc=%0d fe=%0d",
                    e.name, f_stall, d_stall, d_flush, e_flush,
                    e_forward_a, e_forward_b, stall_cycles, flush_events,
                    e.fs, e.fs, e.df, e.ef, e.fa, e.fb, e.sc, e.fe);
            end
        end
    end

    initial begin
        idle();
        rst = 1;
        exp_sc = 0; exp_fe = 0;

        // second reset cycle with hazards present: outputs gated to 0
        next_cycle();
        rst = 1;
        e_result_src = 2'b01; e_rd = 5; d_rs1 = 5; d_use_rs1 = 1;
        e_pc_src = 1; m_reg_write = 1; m_rd = 3; e_rs1 = 3;
        expect_vec("rst_gate", 0, 0, 0, 2'b00, 2'b00);

        next_cycle();
        e_result_src = 2'b01; e_reg_write = 1; e_rd = 5;
        d_rs1 = 5; d_use_rs1 = 1;
        expect_vec("load_use", 1, 0, 1, 2'b00, 2'b00);

        next_cycle();
        w_reg_write = 1; w_rd = 5; e_rs1 = 5;
        expect_vec("load_fwd_w", 0, 0, 0, 2'b01, 2'b00);

        next_cycle();
        e_result_src = 2'b01; e_reg_write = 1; e_rd = 0;
        d_rs1 = 0; d_use_rs1 = 1;
        expect_vec("load_x0", 0, 0, 0, 2'b00, 2'b00);

        next_cycle();
        e_result_src = 2'b11; e_reg_write = 1; e_rd = 7;
        d_rs1 = 7; d_use_rs1 = 1;
        expect_vec("div_in_e_raw", 1, 0, 1, 2'b00, 2'b00);

        next_cycle();
        md_busy = 1; d_rs1 = 7; d_use_rs1 = 1;
        expect_vec("sb_raw_1", 1, 0, 1, 2'b00, 2'b00);

        next_cycle();
        md_busy = 1; d_rs1 = 7; d_use_rs1 = 1;
        expect_vec("sb_raw_2", 1, 0, 1, 2'b00, 2'b00);

        next_cycle();
        md_busy = 1; d_reg_write = 1; d_rd = 7;
        expect_vec("waw_alu_x7", 1, 0, 1, 2'b00, 2'b00);

        next_cycle();
        md_busy = 1; d_is_md = 1; d_rd = 8; d_reg_write = 1;
        expect_vec("struct_md_busy", 1, 0, 1, 2'b00, 2'b00);

        next_cycle();
        md_done = 1; md_rd = 7; d_rs1 = 7; d_use_rs1 = 1;
        expect_vec("done_cycle_still_stall", 1, 0, 1, 2'b00, 2'b00);

        next_cycle();
        d_rs1 = 7; d_use_rs1 = 1;
        expect_vec("after_done_issue", 0, 0, 0, 2'b00, 2'b00);

        next_cycle();
        md_done = 1; md_rd = 9; e_rs1 = 9; e_rs2 = 9;
        expect_vec("md_fwd", 0, 0, 0, 2'b11, 2'b11);

        next_cycle();
        md_done = 1; md_rd = 9; e_rs1 = 9;
        m_reg_write = 1; m_rd = 9;
        e_rs2 = 4; w_reg_write = 1; w_rd = 4;
        expect_vec("m_over_md", 0, 0, 0, 2'b10, 2'b01);

        next_cycle();
        m_reg_write = 1; m_rd = 0; w_reg_write = 1; w_rd = 0;
        md_done = 1; md_rd = 0;
        expect_vec("fwd_x0", 0, 0, 0, 2'b00, 2'b00);

        next_cycle();
        e_pc_src = 1;
        e_result_src = 2'b01; e_reg_write = 1; e_rd = 5;
        d_rs1 = 5; d_use_rs1 = 1;
        expect_vec("redirect_over_stall", 0, 1, 1, 2'b00, 2'b00);

        next_cycle();
        expect_vec("idle_counters", 0, 0, 0, 2'b00, 2'b00);

        next_cycle();
        e_result_src = 2'b11; e_reg_write = 1; e_rd = 7;
        expect_vec("mul_in_e_no_dep", 0, 0, 0, 2'b00, 2'b00);

        next_cycle();
        md_busy = 1; d_rs2 = 7; d_use_rs2 = 1;
        expect_vec("sb_raw_rs2", 1, 0, 1, 2'b00, 2'b00);

        next_cycle();
        rst = 1; d_rs2 = 7; d_use_rs2 = 1;
        expect_vec("rst_mid_op", 0, 0, 0, 2'b00, 2'b00);

        next_cycle();
        d_rs2 = 7; d_use_rs2 = 1;
        expect_vec("after_rst_no_stall", 0, 0, 0, 2'b00, 2'b00);

        next_cycle();
        drive_done = 1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (drive_done);
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
